// File: rtl/neuron_scheduler_pkg.sv
// Shared types and elaboration helpers for the neuron scheduler and its cycle timer.
package neuron_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCur,
    StUv,
    StWb,
    StWait
  } state_e;

  // Clocks spent on one neuron: current phase, u/v phase, one writeback clock.
  function automatic int unsigned slot_len(input int unsigned i_time,
                                           input int unsigned uv_time);
    return i_time + uv_time + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_scheduler_cycle_timer.sv
// Free-running computation-cycle counter; held at zero while the scheduler is idle.
module neuron_scheduler_cycle_timer
  import neuron_scheduler_pkg::*;
#(
  parameter int unsigned comp_cycle_time = 1000,
  localparam int unsigned CW = idx_width(comp_cycle_time)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic last_o
);

  logic [CW-1:0] cyc_q, cyc_d;

  assign last_o = (cyc_q == CW'(comp_cycle_time - 1));

  always_comb begin
    cyc_d = cyc_q + CW'(1);
    if (clear_i || last_o) begin
      cyc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Sequences every neuron through current, u/v and writeback once per computation cycle,
// and publishes the collected spike vector when the cycle ends.
module neuron_scheduler
  import neuron_scheduler_pkg::*;
#(
  parameter int unsigned Nn              = 4,
  parameter int unsigned i_time          = 8,
  parameter int unsigned uv_time         = 8,
  parameter int unsigned comp_cycle_time = 1000,
  localparam int unsigned NW = idx_width(Nn)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          spike_in_i,
  output logic [NW-1:0] nidx_o,
  output logic          i_start_o,
  output logic          uv_start_o,
  output logic          wr_en_o,
  output logic [Nn-1:0] spikearray_o,
  output logic          cycle_done_o,
  output logic          busy_o
);

  localparam int unsigned Slot  = slot_len(i_time, uv_time);
  localparam int unsigned PhMax = (i_time > uv_time) ? i_time : uv_time;
  localparam int unsigned PW    = idx_width(PhMax);

  if ((comp_cycle_time < Nn * Slot + 1) || (i_time == 0) || (uv_time == 0)) begin : g_bad_cfg
    $error("neuron_scheduler: comp_cycle_time too short for Nn neuron slots");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [NW-1:0] nidx_q, nidx_d;
  logic [Nn-1:0] shadow_q, shadow_d;
  logic [Nn-1:0] spikes_q, spikes_d;
  logic          cyc_last;

  neuron_scheduler_cycle_timer #(
    .comp_cycle_time(comp_cycle_time)
  ) u_cycle_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(state_q == StIdle),
    .last_o (cyc_last)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    nidx_d       = nidx_q;
    shadow_d     = shadow_q;
    spikes_d     = spikes_q;
    i_start_o    = 1'b0;
    uv_start_o   = 1'b0;
    wr_en_o      = 1'b0;
    cycle_done_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        nidx_d  = '0;
        phase_d = '0;
        if (enable_i) state_d = StCur;
      end
      StCur: begin
        i_start_o = (phase_q == '0);
        if (phase_q == PW'(i_time - 1)) begin
          phase_d = '0;
          state_d = StUv;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StUv: begin
        uv_start_o = (phase_q == '0);
        if (phase_q == PW'(uv_time - 1)) begin
          phase_d = '0;
          state_d = StWb;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StWb: begin
        wr_en_o          = 1'b1;
        shadow_d[nidx_q] = spike_in_i;
        if (nidx_q == NW'(Nn - 1)) begin
          state_d = StWait;
        end else begin
          nidx_d  = nidx_q + NW'(1);
          state_d = StCur;
        end
      end
      StWait: begin
        // enable is only re-sampled here, so a mid-cycle drop still publishes this cycle.
        if (cyc_last) begin
          cycle_done_o = 1'b1;
          spikes_d     = shadow_q;
          shadow_d     = '0;
          nidx_d       = '0;
          state_d      = enable_i ? StCur : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      nidx_q   <= '0;
      shadow_q <= '0;
      spikes_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      nidx_q   <= nidx_d;
      shadow_q <= shadow_d;
      spikes_q <= spikes_d;
    end
  end

  assign nidx_o       = nidx_q;
  assign spikearray_o = spikes_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench: stimulus queues expected pulses with their clock stamps, a monitor pops
// and compares each pulse the scheduler emits.
module tb_neuron_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       enable_i;
  logic       spike_in_i;
  logic [1:0] nidx_o;
  logic       i_start_o;
  logic       uv_start_o;
  logic       wr_en_o;
  logic [3:0] spikearray_o;
  logic       cycle_done_o;
  logic       busy_o;

  neuron_scheduler dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .spike_in_i  (spike_in_i),
    .nidx_o      (nidx_o),
    .i_start_o   (i_start_o),
    .uv_start_o  (uv_start_o),
    .wr_en_o     (wr_en_o),
    .spikearray_o(spikearray_o),
    .cycle_done_o(cycle_done_o),
    .busy_o      (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Event kinds: 0 i_start, 1 uv_start, 2 wr_en, 3 cycle_done, 4 published spikearray.
  typedef struct {
    int     kind;
    int     val;
    longint t;
  } ev_t;

  ev_t    exp_q[$];
  longint tcnt = 0;
  int     checks = 0;
  int     errors = 0;
  bit     spk_pend = 0;

  always @(posedge clk_i) tcnt <= tcnt + 1;

  task automatic push(input int kind, input int val, input longint t);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.t    = t;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, req, tcnt);
    end
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d val %0d at t=%0d, expected none",
               kind, val, tcnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.t != tcnt) begin
        errors++;
        $display("FAIL event: got kind %0d val %0d t %0d, expected kind %0d val %0d t %0d",
                 kind, val, tcnt, e.kind, e.val, e.t);
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (spk_pend) begin
        spk_pend = 0;
        check_ev(4, int'(spikearray_o));
      end
      if (i_start_o)  check_ev(0, int'(nidx_o));
      if (uv_start_o) check_ev(1, int'(nidx_o));
      if (wr_en_o)    check_ev(2, int'(nidx_o));
      if (cycle_done_o) begin
        check_ev(3, int'(nidx_o));
        spk_pend = 1;
      end
      if (i_start_o || uv_start_o || wr_en_o)
        chk("strobe_exclusive", int'(i_start_o) + int'(uv_start_o) + int'(wr_en_o), 1);
    end
  end

  // base = clock stamp of cyc 0; abort_at limits both the queued events and the driven clocks.
  task automatic run_cycle(input longint base, input logic [3:0] pat, input bit noise,
                           input int dis_at, input int abort_at);
    for (int k = 0; k < 4; k++) begin
      if (17 * k < abort_at)      push(0, k, base + 17 * k);
      if (17 * k + 8 < abort_at)  push(1, k, base + 17 * k + 8);
      if (17 * k + 16 < abort_at) push(2, k, base + 17 * k + 16);
    end
    if (999 < abort_at)  push(3, 3, base + 999);
    if (1000 < abort_at) push(4, int'(pat), base + 1000);
    for (int c = 0; c < 1000 && c < abort_at; c++) begin
      @(negedge clk_i);
      spike_in_i = noise ? c[0] : 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (c == 17 * k + 16) spike_in_i = pat[k];
      end
      if (c == dis_at) enable_i = 1'b0;
    end
  endtask

  initial begin : stimulus
    longint base;
    rst_ni     = 1'b0;
    enable_i   = 1'b0;
    spike_in_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    chk("reset_spikearray", spikearray_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_nidx", nidx_o, 0);
    repeat (50) @(negedge clk_i);
    chk("idle_busy", busy_o, 0);
    chk("idle_spikearray", spikearray_o, 0);

    // Four back-to-back cycles; the last drops enable at cyc 30.
    enable_i = 1'b1;
    base = tcnt + 1;
    run_cycle(base, 4'b0100, 1'b0, -1, 2000);
    run_cycle(base + 1000, 4'b1001, 1'b0, -1, 2000);
    run_cycle(base + 2000, 4'b0000, 1'b1, -1, 2000);
    run_cycle(base + 3000, 4'b1111, 1'b0, 30, 2000);
    @(negedge clk_i);
    chk("after_disable_busy", busy_o, 0);
    repeat (20) @(negedge clk_i);
    chk("idle_hold_busy", busy_o, 0);
    chk("idle_hold_spikearray", spikearray_o, 4'b1111);

    // Reset at cyc 40 of a fresh cycle.
    enable_i = 1'b1;
    base = tcnt + 1;
    run_cycle(base, 4'b0110, 1'b0, -1, 40);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midreset_spikearray", spikearray_o, 0);
    chk("midreset_busy", busy_o, 0);
    chk("midreset_nidx", nidx_o, 0);
    chk("midreset_i_start", i_start_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    base = tcnt + 1;
    run_cycle(base, 4'b0010, 1'b0, 500, 2000);
    @(negedge clk_i);
    chk("final_busy", busy_o, 0);
    repeat (5) @(negedge clk_i);
    chk("final_spikearray", spikearray_o, 4'b0010);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
